// File: rtl/seq_detect_param.sv
// Runtime-programmable serial bit-sequence detector with Moore match flag
// and saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   in_valid     qualifies in
//   in           serial data bit
//   cfg_load     latch pattern/pat_len/overlap_en, clear detection history
//   pattern      pattern bits, pattern[pat_len-1] is received first
//   pat_len      pattern length (0 = never match, >N clamps to N)
//   overlap_en   1 = overlapping detection, 0 = non-overlapping
//   count_clr    clear match_count (wins over a same-cycle increment)
//   out          single-cycle match flag (high while in MATCH)
//   match_count  saturating match count
module seq_detect_param #(
  parameter int unsigned N     = 5,
  parameter int unsigned LEN_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [N-1:0]     pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] N_LEN   = LEN_W'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [N-1:0]     hist;
  logic [LEN_W-1:0] fill;

  logic [LEN_W-1:0] len_clamp_c;
  logic [N-1:0]     new_hist_c;
  logic [LEN_W-1:0] new_fill_c;
  logic [N-1:0]     mask_c;
  logic             accept_c;
  logic             hit_c;

  // Next history/fill for an accepted bit and the match decision on it.
  always_comb begin
    len_clamp_c = (pat_len > N_LEN) ? N_LEN : pat_len;
    new_hist_c  = {hist[N-2:0], in};
    new_fill_c  = (fill >= N_LEN) ? N_LEN : fill + LEN_W'(1);
    mask_c      = '0;
    for (int i = 0; i < int'(N); i++) begin
      mask_c[i] = (LEN_W'(i) < len_q);
    end
    accept_c = in_valid && !cfg_load && (state != IDLE);
    // Only the low L history bits are compared; fill guards against
    // matching on the zeroed history left by a load or non-overlap restart.
    hit_c = accept_c && (len_q != '0) && (new_fill_c >= len_q) &&
            ((new_hist_c & mask_c) == (pat_q & mask_c));
  end

  // FSM, datapath and counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      out         <= 1'b0;
      match_count <= '0;
      hist        <= '0;
      fill        <= '0;
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
    end else begin
      if (count_clr) begin
        match_count <= '0;
      end else if (hit_c && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end

      if (cfg_load) begin
        pat_q <= pattern;
        len_q <= len_clamp_c;
        ovl_q <= overlap_en;
        hist  <= '0;
        fill  <= '0;
        state <= HUNT;
        out   <= 1'b0;
      end else if (state != IDLE) begin
        if (in_valid) begin
          hist <= new_hist_c;
          // Non-overlap: a match restarts the fill so its bits cannot be reused.
          fill <= (hit_c && !ovl_q) ? '0 : new_fill_c;
        end
        state <= hit_c ? MATCH : HUNT;
        out   <= hit_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised + directed bench for seq_detect_param against a queue-based
// reference model of the accepted bit stream.
module tb_seq_detect_param;

  localparam int unsigned N     = 5;
  localparam int unsigned LEN_W = 3;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [N-1:0]     pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap_en;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  seq_detect_param #(.N(N), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in         (in),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .count_clr  (count_clr),
    .out        (out),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: configured flag, latched config, bits seen.
  bit        m_cfg;
  bit [N-1:0] m_pat;
  int        m_len;
  bit        m_ovl;
  bit        m_q[$];
  bit        m_out;
  int        m_cnt;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented now.
  task automatic model_edge();
    bit hit;
    hit = 1'b0;
    if (!rst) begin
      m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0;
      m_q.delete(); m_cnt = 0;
    end else begin
      if (cfg_load) begin
        m_cfg = 1;
        m_pat = pattern;
        m_len = (int'(pat_len) > int'(N)) ? int'(N) : int'(pat_len);
        m_ovl = overlap_en;
        m_q.delete();
      end else if (m_cfg && in_valid) begin
        m_q.push_back(in);
        if (m_q.size() > 16) void'(m_q.pop_front());
        if (m_len > 0 && m_q.size() >= m_len) begin
          hit = 1'b1;
          // Oldest of the last L bits must equal pattern[L-1].
          for (int k = 0; k < m_len; k++)
            if (m_q[m_q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_q.delete();
      end
      if (count_clr) m_cnt = 0;
      else if (hit && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
    m_out = hit;
  endtask

  // One clock: inputs already set; update model, then compare after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("out", int'(out), int'(m_out));
    check("match_count", int'(match_count), m_cnt);
  endtask

  task automatic quiet();
    rst = 1'b1; in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
  endtask

  task automatic send(input bit b);
    quiet(); in_valid = 1'b1; in = b; tick();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin quiet(); tick(); end
  endtask

  task automatic load(input logic [N-1:0] p, input int l, input bit o);
    quiet(); cfg_load = 1'b1; pattern = p; pat_len = LEN_W'(l); overlap_en = o;
    tick();
  endtask

  task automatic clear();
    quiet(); count_clr = 1'b1; tick();
  endtask

  task automatic send_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send(bits[i]);
  endtask

  initial begin
    logic [31:0] s;
    quiet(); pattern = '0; pat_len = '0; overlap_en = 1'b0;
    m_cfg = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_out = 0; m_cnt = 0;

    // Reset, then stream without configuration: nothing happens.
    rst = 1'b0; @(posedge clk); model_edge(); rst = 1'b0; tick();
    check("reset_out", int'(out), 0);
    check("reset_cnt", int'(match_count), 0);
    s = 32'b11011; send_seq(s, 5);
    check("idle_cnt", int'(match_count), 0);

    // Overlapping 11011 on 11011011: two pulses.
    load(5'b11011, 5, 1'b1);
    send(1); send(1); send(0); send(1);
    check("ovl_pre", int'(out), 0);
    send(1);
    check("ovl_p1", int'(out), 1);
    send(0); check("ovl_drop", int'(out), 0);
    send(1); send(1);
    check("ovl_p2", int'(out), 1);
    check("ovl_cnt", int'(match_count), 2);

    // Non-overlapping: one pulse, second needs a fresh 011.
    clear();
    load(5'b11011, 5, 1'b0);
    s = 32'b11011011; send_seq(s, 8);
    check("novl_cnt", int'(match_count), 1);
    s = 32'b011; send_seq(s, 3);
    check("novl_p2", int'(out), 1);
    check("novl_cnt2", int'(match_count), 2);

    // 101 with 2-cycle gaps, overlapping.
    clear();
    load(5'b00101, 3, 1'b1);
    s = 32'b10101;
    for (int i = 4; i >= 0; i--) begin send(s[i]); if (i > 0) gap(2); end
    check("gap_cnt", int'(match_count), 2);

    // Length 7 clamps to 5.
    clear();
    load(5'b10101, 7, 1'b1);
    for (int i = 4; i >= 0; i--) begin send(s[i]); if (i > 0) gap(2); end
    check("clamp_cnt", int'(match_count), 1);

    // Reconfigure mid-sequence; bit with cfg_load discarded.
    clear();
    load(5'b11011, 5, 1'b1);
    send(1); send(1); send(0); send(1);
    quiet(); cfg_load = 1'b1; in_valid = 1'b1; in = 1'b1; tick();
    send(1);
    check("reload_nomatch", int'(out), 0);
    s = 32'b11011; send_seq(s, 5);
    check("reload_match", int'(out), 1);

    // Saturation with L = 1 and clear colliding with a match.
    clear();
    load(5'b00001, 1, 1'b1);
    for (int i = 0; i < 5; i++) send(1);
    check("sat_cnt", int'(match_count), 3);
    quiet(); in_valid = 1'b1; in = 1'b1; count_clr = 1'b1; tick();
    check("clr_prio", int'(match_count), 0);
    check("clr_out", int'(out), 1);

    // pat_len = 0 never matches.
    load(5'b00000, 0, 1'b1);
    for (int i = 0; i < 6; i++) send(0);
    check("len0_cnt", int'(match_count), 0);

    // Randomised traffic.
    for (int c = 0; c < 4000; c++) begin
      quiet();
      rst       = ($urandom_range(0, 299) != 0);
      cfg_load  = ($urandom_range(0, 59) == 0);
      count_clr = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in        = 1'($urandom);
      if (cfg_load) begin
        pattern    = N'($urandom);
        pat_len    = LEN_W'($urandom_range(0, 7));
        overlap_en = 1'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised, runtime-programmable serial bit-sequence detector with a Moore output and a saturating match counter. It generalises the fixed-pattern Moore detector: pattern value, pattern length (1..N) and overlap/non-overlap mode are loaded at run time. It sits on a serial bit stream qualified by `in_valid` and feeds a single-cycle `out` flag and a `match_count` to status logic.

## Interface
- `N`, default 5: maximum pattern length in bits (N ≥ 2).
- `LEN_W`, default 3: width of `pat_len`. Must satisfy 2^LEN_W > N.
- `CNT_W`, default 16: width of `match_count`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-low reset. Sampled on `clk`; low forces the reset state.
- `in_valid`  in  1  qualifies `in` this cycle.
- `in`  in  1  serial data bit.
- `cfg_load`  in  1  one-cycle pulse that latches `pattern`, `pat_len` and `overlap_en`, and clears detection history.
- `pattern`  in  N  pattern bits. `pattern[pat_len-1]` is the first bit received; `pattern[0]` is the last.
- `pat_len`  in  LEN_W  pattern length.
- `overlap_en`  in  1  1 selects overlapping detection; 0 selects non-overlapping detection.
- `count_clr`  in  1  synchronously clears `match_count`.
- `out`  out  1  Moore match flag (high exactly while the FSM is in MATCH).
- `match_count`  out  CNT_W  number of matches, saturating.

## Operation
- FSM states:
  - IDLE: not configured; input is ignored.
  - HUNT: searching for the pattern.
  - MATCH: the last accepted bit completed the pattern.
- `out` = (state == MATCH).
- Datapath: N-bit history shift register `hist` (new bit enters at bit 0) and a fill counter `fill` (0..N, saturating at N).
- Configuration:
  - `cfg_load` = 1 → latch the config, `hist` ← 0, `fill` ← 0, state ← HUNT.
  - `pat_len` = 0 → valid config, but no match is ever detected.
  - `pat_len` > N → clamped to N.
- Accepted bit (`in_valid` = 1, state HUNT or MATCH, no `cfg_load`):
  - `hist` ← {hist[N-2:0], in}; `fill` ← min(fill+1, N).
  - A match occurs when the new `fill` ≥ L and the new `hist[L-1:0]` == `pattern[L-1:0]` (L = clamped `pat_len`, L ≥ 1).
  - Match → state ← MATCH and `match_count` increments. If `overlap_en` = 0, `fill` ← 0 instead of incrementing.
  - No match → state ← HUNT.
- No accepted bit while in MATCH → state ← HUNT. `out` is therefore always a single-cycle pulse per match.
- Counter: saturates at 2^CNT_W − 1. `count_clr` has priority over an increment in the same cycle (result is 0, and that match is not counted).
- Priority per cycle: `rst` low > `cfg_load` > accepted bit. A bit presented with `cfg_load` is discarded.
- Reconfiguring mid-sequence discards any partial match. A pending MATCH state drops to HUNT.

## Timing
- Reset values (`rst` = 0 at an edge):
  - state IDLE, `out` 0, `match_count` 0, `hist` 0, `fill` 0.
  - Latched pattern 0, latched length 0, latched overlap 0.
- Latency: `out` rises in the cycle after the clock edge that samples the final pattern bit, and stays high for exactly 1 cycle. `match_count` updates on that same edge.
- Back-to-back matches (overlap mode, L = 1 or periodic patterns) keep `out` high on consecutive cycles, with one increment per cycle.
- `in_valid` gaps do not break a partial match. History advances only on accepted bits.
- In IDLE, `in_valid`/`in` have no effect until the first `cfg_load`.
- `rst` asserted mid-sequence takes effect at the next edge, and the detector returns to IDLE (a new `cfg_load` is required).

## Test plan
- Reset/IDLE: hold `rst` = 0 for 2 cycles, release, then stream 11011 without `cfg_load` → `out` stays 0, `match_count` = 0.
- Overlap: load pattern = 5'b11011, L = 5, `overlap_en` = 1, then stream 1,1,0,1,1,0,1,1 with `in_valid` = 1 → `out` pulses after bit 5 and after bit 8, `match_count` = 2.
- Non-overlap: same config with `overlap_en` = 0 and the same stream → a single pulse after bit 5, `match_count` = 1. Appending 0,1,1 gives a second pulse after bit 11.
- Length/gaps: load pattern = 3'b101, L = 3; stream 1,0,1,0,1 with `in_valid` low for 2 cycles between each bit → pulses after bits 3 and 5 (overlap). Repeat with L = 7 at N = 5 → behaves as L = 5.
- Reconfigure mid-sequence: after 1,1,0,1 of 11011, pulse `cfg_load` (same config) with `in` = 1 and `in_valid` = 1 in that cycle → no match on the next bit; a full 11011 is needed.
- Counter: CNT_W = 2; produce 5 matches → count sticks at 3. `count_clr` in the same cycle as a match → count = 0.
